// File: rtl/regs_dbg_arbiter_if.sv
`default_nettype none
// ============================================================================
// regs_dbg_arbiter_if : debugger request/response handshake bundle
// Rev 1.0 : initial release
// ============================================================================
interface regs_dbg_arbiter_if;
    logic        dbg_req_valid;
    logic        dbg_req_write;
    logic [4:0]  dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_req_ready;
    logic        dbg_resp_valid;
    logic [31:0] dbg_resp_rdata;
    logic        dbg_resp_err;
    logic        dbg_resp_ready;

    modport master (
        output dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata,
        output dbg_resp_ready,
        input  dbg_req_ready, dbg_resp_valid, dbg_resp_rdata, dbg_resp_err
    );

    modport slave (
        input  dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata,
        input  dbg_resp_ready,
        output dbg_req_ready, dbg_resp_valid, dbg_resp_rdata, dbg_resp_err
    );
endinterface
`default_nettype wire

// File: rtl/regs_dbg_arbiter.sv
`default_nettype none
// ============================================================================
// regs_dbg_arbiter : shares the register file write/read-3 ports between the
// pipeline writeback and a debugger.  Rev 1.0 : initial release
// ============================================================================
module regs_dbg_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    regs_dbg_arbiter_if.slave dbg,
    input  wire logic        wb_we,
    input  wire logic [4:0]  wb_addr,
    input  wire logic [31:0] wb_val,
    output logic             pipe_stall,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wval,
    output logic [4:0]       rf_raddr3,
    input  wire logic [31:0] rf_rval3
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD      = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;
    localparam logic [3:0] c_limit   = 4'(STARVE_LIMIT);

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_write;
    logic [4:0]  r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;
    logic        r_stall;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_addr_zero;
    logic        w_grant;
    logic        w_wr_done;
    logic [31:0] w_rd_val;

    assign w_accept    = dbg.dbg_req_valid && dbg.dbg_req_ready;
    assign w_addr_zero = (r_addr == 5'd0);
    assign w_grant     = (r_state == S_WR_WAIT) && !wb_we && !w_addr_zero;
    assign w_wr_done   = (r_state == S_WR_WAIT) && (w_addr_zero || !wb_we);
    // A writeback landing on the address being read this cycle wins over the stale port value.
    assign w_rd_val    = (wb_we && (wb_addr == r_addr) && !w_addr_zero) ? wb_val : rf_rval3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = dbg.dbg_req_write ? S_WR_WAIT : S_RD;
            S_RD:      w_next = S_RESP;
            S_WR_WAIT: if (w_wr_done) w_next = S_RESP;
            S_RESP:    if (dbg.dbg_resp_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        dbg.dbg_req_ready  = (r_state == S_IDLE) && rst_n;
        dbg.dbg_resp_valid = (r_state == S_RESP);
        dbg.dbg_resp_rdata = r_rdata;
        dbg.dbg_resp_err   = r_err;
        pipe_stall         = r_stall;
        rf_raddr3          = r_addr;
        rf_we              = wb_we;
        rf_waddr           = wb_addr;
        rf_wval            = wb_val;
        if (w_grant) begin
            rf_we    = 1'b1;
            rf_waddr = r_addr;
            rf_wval  = r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_addr  <= 5'd0;
            r_wdata <= 32'd0;
            r_cnt   <= 4'd0;
            r_stall <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= dbg.dbg_req_write;
                        r_addr  <= dbg.dbg_req_addr;
                        r_wdata <= dbg.dbg_req_wdata;
                    end
                end
                S_RD: begin
                    r_rdata <= w_rd_val;
                    r_err   <= 1'b0;
                end
                S_WR_WAIT: begin
                    if (w_wr_done) begin
                        r_rdata <= 32'd0;
                        r_err   <= w_addr_zero;
                        r_stall <= 1'b0;
                    end else begin
                        if (r_cnt != c_limit) r_cnt <= r_cnt + 4'd1;
                        // Stall is requested once the wait has been at the limit for a full cycle.
                        if (r_cnt == c_limit) r_stall <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (dbg.dbg_resp_ready) r_cnt <= 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regs_dbg_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regs_dbg_arbiter : scoreboard bench with a register file model.
// Rev 1.0 : initial release
// ============================================================================
module tb_regs_dbg_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_val;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wval;
    logic [4:0]  rf_raddr3;
    logic [31:0] rf_rval3;

    regs_dbg_arbiter_if dbg();

    regs_dbg_arbiter #(.STARVE_LIMIT(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dbg        (dbg.slave),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_val     (wb_val),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wval    (rf_wval),
        .rf_raddr3  (rf_raddr3),
        .rf_rval3   (rf_rval3)
    );

    always #5 clk = ~clk;

    logic [31:0] rf     [32];
    logic [31:0] exp_rf [32];
    logic [32:0] sb [$];
    logic [32:0] e;
    int          n_chk  = 0;
    int          n_pass = 0;

    always @(posedge clk) if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wval;
    assign rf_rval3 = (rf_raddr3 == 5'd0) ? 32'd0 : rf[rf_raddr3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    endtask

    always @(negedge clk) begin
        if (rst_n && dbg.dbg_resp_valid && dbg.dbg_resp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", dbg.dbg_resp_rdata, e[31:0]);
                chk("resp_err", {31'd0, dbg.dbg_resp_err}, {31'd0, e[32]});
            end
        end
    end

    task automatic dbg_txn(input logic wr, input logic [4:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        @(posedge clk) #1;
        dbg.dbg_req_valid = 1'b1;
        dbg.dbg_req_write = wr;
        dbg.dbg_req_addr  = a;
        dbg.dbg_req_wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dbg.dbg_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("req_ready_timeout", 32'd0, 32'd1);
        if (wr) begin
            sb.push_back({(a == 5'd0), 32'd0});
            if (a != 5'd0) exp_rf[a] = d;
        end else begin
            sb.push_back({1'b0, (a == 5'd0) ? 32'd0 : exp_rf[a]});
        end
        @(posedge clk) #1;
        dbg.dbg_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("resp_timeout", sb.size(), 32'd0);
    endtask

    int          hits;
    logic [31:0] saved;

    initial begin
        for (int i = 0; i < 32; i++) begin rf[i] = 32'd0; exp_rf[i] = 32'd0; end
        rst_n = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd9; wb_val = 32'h0BAD_0009;
        dbg.dbg_req_valid = 1'b0; dbg.dbg_req_write = 1'b0;
        dbg.dbg_req_addr = 5'd0; dbg.dbg_req_wdata = 32'd0;
        dbg.dbg_resp_ready = 1'b1;
        exp_rf[9] = 32'h0BAD_0009;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, dbg.dbg_req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, dbg.dbg_resp_valid}, 32'd0);
        chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
        chk("rst_rdata", dbg.dbg_resp_rdata, 32'd0);
        chk("rst_raddr3", {27'd0, rf_raddr3}, 32'd0);
        chk("rst_rf_we_pass", {31'd0, rf_we}, 32'd1);
        chk("rst_rf_waddr_pass", {27'd0, rf_waddr}, 32'd9);
        @(posedge clk) #1;
        wb_we = 1'b0;
        rst_n = 1'b1;

        // pipeline writeback r5, then debug read
        @(posedge clk) #1;
        wb_we = 1'b1; wb_addr = 5'd5; wb_val = 32'h0000_1234; exp_rf[5] = 32'h1234;
        #1;
        chk("wb_pass_we", {31'd0, rf_we}, 32'd1);
        chk("wb_pass_val", rf_wval, 32'h1234);
        @(posedge clk) #1;
        wb_we = 1'b0;
        dbg_txn(1'b0, 5'd5, 32'd0);
        @(negedge clk);
        chk("rd_lat1_valid", {31'd0, dbg.dbg_resp_valid}, 32'd0);
        @(negedge clk);
        chk("rd_lat2_valid", {31'd0, dbg.dbg_resp_valid}, 32'd1);
        wait_done();

        // debug write r7, idle pipeline
        dbg_txn(1'b1, 5'd7, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr7_rf_we", {31'd0, rf_we}, 32'd1);
        chk("wr7_waddr", {27'd0, rf_waddr}, 32'd7);
        chk("wr7_wval", rf_wval, 32'hDEAD_BEEF);
        wait_done();
        dbg_txn(1'b0, 5'd7, 32'd0);
        wait_done();

        // contention on r3 with pipeline writing r12
        @(posedge clk) #1;
        wb_we = 1'b1; wb_addr = 5'd12; wb_val = 32'hA5A5_A5A5; exp_rf[12] = 32'hA5A5_A5A5;
        dbg_txn(1'b1, 5'd3, 32'h0000_0033);
        hits = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (pipe_stall) hits++;
        end
        chk("stall_early", hits, 32'd0);
        @(negedge clk);
        chk("stall_rise", {31'd0, pipe_stall}, 32'd1);
        @(negedge clk);
        chk("stall_pipe_we", {31'd0, rf_we}, 32'd1);
        chk("stall_pipe_addr", {27'd0, rf_waddr}, 32'd12);
        chk("stall_pipe_val", rf_wval, 32'hA5A5_A5A5);
        @(posedge clk) #1;
        wb_we = 1'b0;
        @(negedge clk);
        chk("grant_addr", {27'd0, rf_waddr}, 32'd3);
        chk("grant_val", rf_wval, 32'h33);
        chk("grant_stall_held", {31'd0, pipe_stall}, 32'd1);
        @(negedge clk);
        chk("stall_clear", {31'd0, pipe_stall}, 32'd0);
        wait_done();
        dbg_txn(1'b0, 5'd3, 32'd0);
        wait_done();
        dbg_txn(1'b0, 5'd12, 32'd0);
        wait_done();

        // write to r0
        dbg_txn(1'b1, 5'd0, 32'h0000_00FF);
        @(negedge clk);
        chk("wr0_no_we", {31'd0, rf_we}, 32'd0);
        wait_done();
        dbg_txn(1'b0, 5'd0, 32'd0);
        wait_done();

        // response backpressure
        dbg.dbg_resp_ready = 1'b0;
        dbg_txn(1'b0, 5'd5, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, dbg.dbg_resp_valid}, 32'd1);
            chk("bp_rdata", dbg.dbg_resp_rdata, 32'h1234);
            chk("bp_req_ready", {31'd0, dbg.dbg_req_ready}, 32'd0);
        end
        @(posedge clk) #1;
        dbg.dbg_resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle", {31'd0, dbg.dbg_req_ready}, 32'd1);

        // reset during WR_WAIT
        @(posedge clk) #1;
        wb_we = 1'b1; wb_addr = 5'd14; wb_val = 32'h0000_0077; exp_rf[14] = 32'h77;
        saved = exp_rf[9];
        dbg_txn(1'b1, 5'd9, 32'h0000_0099);
        @(negedge clk);
        @(posedge clk) #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", {31'd0, dbg.dbg_req_ready}, 32'd0);
        chk("mid_rst_resp_valid", {31'd0, dbg.dbg_resp_valid}, 32'd0);
        chk("mid_rst_rdata", dbg.dbg_resp_rdata, 32'd0);
        chk("mid_rst_raddr3", {27'd0, rf_raddr3}, 32'd0);
        chk("mid_rst_we_pass", {31'd0, rf_we}, 32'd1);
        chk("mid_rst_waddr_pass", {27'd0, rf_waddr}, 32'd14);
        sb.delete();
        exp_rf[9] = saved;
        @(posedge clk) #1;
        wb_we = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if ((rf_we && rf_waddr == 5'd9) || dbg.dbg_resp_valid) hits++;
        end
        chk("no_stale_write", hits, 32'd0);
        dbg_txn(1'b0, 5'd9, 32'd0);
        wait_done();
        dbg_txn(1'b0, 5'd14, 32'd0);
        wait_done();

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regs_dbg_arbiter.md
REGS_DBG_ARBITER -- requirements
Module: regs_dbg_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8, range 1..15: number of cycles a pending debug write waits behind pipeline writebacks before stalling the pipeline.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports wb_we, wb_addr, wb_val, input, 1/5/32: pipeline writeback request.
REQ-005 The block SHALL have port pipe_stall, output, 1: registered request that the pipeline hold off writeback.
REQ-006 The block SHALL have ports dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata, input, 1/1/5/32: debugger request (write=1 means write).
REQ-007 The block SHALL have port dbg_req_ready, output, 1: request accepted on valid&&ready.
REQ-008 The block SHALL have ports dbg_resp_valid, dbg_resp_rdata, dbg_resp_err, output, 1/32/1, and dbg_resp_ready, input, 1: debugger response handshake.
REQ-009 The block SHALL have ports rf_we, rf_waddr, rf_wval, output, 1/5/32: register file write port.
REQ-010 The block SHALL have ports rf_raddr3, output, 5, and rf_rval3, input, 32: register file debug read port.

Function
REQ-011 The block SHALL implement states IDLE, RD, WR_WAIT, RESP, encoded in a single state register.
REQ-012 The block SHALL drive dbg_req_ready=1 only in IDLE with rst_n high; on accept it SHALL latch write, addr and wdata, then go to RD (read) or WR_WAIT (write).
REQ-013 The block SHALL drive rf_raddr3 from the latched address register at all times.
REQ-014 In RD, the block SHALL capture rf_rval3 into dbg_resp_rdata at the clock edge, set err=0 and go to RESP; a same-cycle writeback to that address yields the bypassed new value.
REQ-015 In WR_WAIT with wb_we=0, the block SHALL grant the write port for one cycle: rf_we=1, rf_waddr=latched addr, rf_wval=latched wdata; it SHALL set rdata=0, err=0 and go to RESP.
REQ-016 In WR_WAIT with wb_we=1, the pipeline SHALL win and the debug write stays pending; the wait counter increments, saturating at STARVE_LIMIT.
REQ-017 When the wait counter equals STARVE_LIMIT, pipe_stall SHALL be 1 from the next edge until the debug write is granted; it SHALL clear on the edge leaving WR_WAIT.
REQ-018 If wb_we stays 1 while pipe_stall=1, the block SHALL keep waiting and never drop or corrupt the pipeline write.
REQ-019 A debug write to address 0 SHALL complete at the first WR_WAIT cycle, without asserting rf_we and regardless of wb_we, with err=1 and rdata=0.
REQ-020 When debug is not granted, the block SHALL make rf_we/rf_waddr/rf_wval equal to wb_we/wb_addr/wb_val combinationally, with zero latency.
REQ-021 In RESP, dbg_resp_valid SHALL be 1 with rdata/err held stable until dbg_resp_ready=1; it SHALL then go to IDLE, clearing the wait counter.
REQ-022 Minimum throughput SHALL be one transaction per 3 cycles (accept, RD/WR_WAIT, RESP with ready=1).

Reset
REQ-023 While rst_n=0, the block SHALL force: state=IDLE, latched addr/wdata=0, wait counter=0, pipe_stall=0, dbg_req_ready=0, dbg_resp_valid=0, rdata=0, err=0, rf_raddr3=0.
REQ-024 A reset mid-transaction SHALL abandon the transaction, with no response and no rf_we from the debug side afterwards.
REQ-025 rf_we during reset SHALL follow wb_we pass-through.

Verification
REQ-026 The bench SHALL cover a debug read: write r5=0x1234 via wb, then request read r5 -> resp_valid 2 cycles after accept, rdata=0x1234, err=0.
REQ-027 The bench SHALL cover a debug write with idle pipeline: write r7=0xDEADBEEF -> rf_we=1 on the cycle after accept with addr 7; a later read returns 0xDEADBEEF.
REQ-028 The bench SHALL cover contention: wb_we held 1 and debug write r3 with STARVE_LIMIT=8 -> pipe_stall rises after 8 wait cycles; wb_we drops -> debug write granted, pipe_stall clears.
REQ-029 The bench SHALL cover a write to r0: request write r0=0xFF -> no debug rf_we, err=1; a read of r0 returns 0.
REQ-030 The bench SHALL cover response backpressure: resp_ready=0 for 5 cycles -> valid/rdata held, req_ready=0; ready=1 -> IDLE next cycle.
REQ-031 The bench SHALL cover reset mid-operation: rst_n low during WR_WAIT -> all outputs at reset values immediately; after release, no stale write occurs.
